// File: rtl/bip_control.sv
// bip_control: fetch/decode control for the accumulator CPU.
// Optional retired-instruction counter when BIP_CYCLE_COUNT_EN is defined.
module bip_control #(
    parameter int PC_BITS     = 11,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic [INSTR_WIDTH-1:0] instr,
    output logic [PC_BITS-1:0]     pc_addr,
    output logic [INSTR_WIDTH-6:0] operand,
    output logic [1:0]             sel_a,
    output logic                   sel_b,
    output logic                   alu_op,
    output logic                   wr_acc,
    output logic                   rd_ram,
    output logic                   wr_ram,
    output logic                   halted
`ifdef BIP_CYCLE_COUNT_EN
    ,
    output logic [15:0]            instr_count
`endif
);

    typedef enum logic [1:0] {
        S_START = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [PC_BITS-1:0]   pc_q, pc_d;
    logic [4:0]           opcode;
    logic                 retire;

    assign opcode  = instr[INSTR_WIDTH-1 -: 5];
    assign operand = instr[INSTR_WIDTH-6:0];
    assign pc_addr = pc_q;
    assign halted  = (state_q == S_HALT);
    assign retire  = (state_q == S_RUN) && run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_START;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sel_a   = 2'b00;
        sel_b   = 1'b0;
        alu_op  = 1'b0;
        wr_acc  = 1'b0;
        rd_ram  = 1'b0;
        wr_ram  = 1'b0;
        unique case (state_q)
            S_START: state_d = S_RUN;
            S_RUN: begin
                if (run) begin
                    // PC wraps naturally at the top of program memory
                    pc_d = pc_q + 1'b1;
                    case (opcode)
                        5'b00000: begin
                            state_d = S_HALT;
                            pc_d    = pc_q;
                        end
                        5'b00001: wr_ram = 1'b1;
                        5'b00010: begin
                            rd_ram = 1'b1;
                            wr_acc = 1'b1;
                        end
                        5'b00011: begin
                            sel_a  = 2'b01;
                            wr_acc = 1'b1;
                        end
                        5'b00100, 5'b00110: begin
                            rd_ram = 1'b1;
                            sel_a  = 2'b10;
                            wr_acc = 1'b1;
                            alu_op = opcode[1];
                        end
                        5'b00101, 5'b00111: begin
                            sel_b  = 1'b1;
                            sel_a  = 2'b10;
                            wr_acc = 1'b1;
                            alu_op = opcode[1];
                        end
                        default: ;
                    endcase
                end
            end
            S_HALT: ;
            default: state_d = S_START;
        endcase
    end

`ifdef BIP_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (retire && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign instr_count = cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule
